// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU pipeline, the arbiter and the MMU access port.
// The arbiter takes the slave view. The pipeline/MMU side (or a bench) takes the master view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [4:0]  mem_bytemode;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall_req;
  logic        mmu_if_read;
  logic        mmu_if_write;
  logic [31:0] mmu_addr;
  logic [31:0] mmu_input_data;
  logic [4:0]  mmu_bytemode;
  logic [31:0] mmu_output_data;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_bytemode,
    input  mmu_output_data,
    output if_rdata, if_ready, mem_rdata, mem_ready, stall_req,
    output mmu_if_read, mmu_if_write, mmu_addr, mmu_input_data, mmu_bytemode
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_bytemode,
    output mmu_output_data,
    input  if_rdata, if_ready, mem_rdata, mem_ready, stall_req,
    input  mmu_if_read, mmu_if_write, mmu_addr, mmu_input_data, mmu_bytemode
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (fetch, load/store) to one-MMU-port arbiter. MEM wins ties because it
// belongs to the older instruction. A pending fetch is always taken right after a
// data access, so IF cannot be starved. Every MMU output is a flop, which keeps the
// MMU outputs steady for the whole issue cycle.
module mem_arbiter (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [4:0] FETCH_BYTEMODE = 5'b01111;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_FETCH} state_t;

  state_t      state, state_nxt;
  logic        mem_eff, if_eff;
  logic        load_mem, load_if;

  logic        rd_nxt, wr_nxt;
  logic [31:0] addr_nxt, wdata_nxt;
  logic [4:0]  bm_nxt;

  logic        mmu_rd_q, mmu_wr_q;
  logic [31:0] mmu_addr_q, mmu_wdata_q;
  logic [4:0]  mmu_bm_q;
  logic        mem_ready_q, if_ready_q;
  logic [31:0] mem_rdata_q, if_rdata_q;

  // A port's request is ignored in its own ready cycle. The requester either drops
  // the request or presents a new one in that cycle.
  assign mem_eff = bus.mem_req & ~mem_ready_q;
  assign if_eff  = bus.if_req  & ~if_ready_q;

  // Next state plus the command the MMU port will see during the next cycle
  always_comb begin
    state_nxt = S_IDLE;
    load_mem  = 1'b0;
    load_if   = 1'b0;
    rd_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    addr_nxt  = 32'h0;
    wdata_nxt = 32'h0;
    bm_nxt    = 5'h0;
    case (state)
      S_IDLE: begin
        if (mem_eff)     load_mem = 1'b1;
        else if (if_eff) load_if  = 1'b1;
      end
      S_DATA:  load_if  = if_eff;
      S_FETCH: load_mem = mem_eff;
      default: ;
    endcase
    if (load_mem) begin
      state_nxt = S_DATA;
      wr_nxt    = bus.mem_we;
      rd_nxt    = ~bus.mem_we;
      addr_nxt  = bus.mem_addr;
      wdata_nxt = bus.mem_wdata;
      bm_nxt    = bus.mem_bytemode;
    end else if (load_if) begin
      state_nxt = S_FETCH;
      rd_nxt    = 1'b1;
      addr_nxt  = bus.if_addr;
      bm_nxt    = FETCH_BYTEMODE;
    end
  end

  // State register. Reset drops any access that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Latch the granted command into the MMU port flops. Reset pulls the write strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmu_rd_q    <= 1'b0;
      mmu_wr_q    <= 1'b0;
      mmu_addr_q  <= 32'h0;
      mmu_wdata_q <= 32'h0;
      mmu_bm_q    <= 5'h0;
    end else begin
      mmu_rd_q    <= rd_nxt;
      mmu_wr_q    <= wr_nxt;
      mmu_addr_q  <= addr_nxt;
      mmu_wdata_q <= wdata_nxt;
      mmu_bm_q    <= bm_nxt;
    end
  end

  // Capture read data on the edge that ends the issue cycle and pulse the matching ready.
  // The MMU clears its output right after that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ready_q <= 1'b0;
      if_ready_q  <= 1'b0;
      mem_rdata_q <= 32'h0;
      if_rdata_q  <= 32'h0;
    end else begin
      mem_ready_q <= (state == S_DATA);
      if_ready_q  <= (state == S_FETCH);
      if (state == S_DATA && mmu_rd_q) mem_rdata_q <= bus.mmu_output_data;
      if (state == S_FETCH)            if_rdata_q  <= bus.mmu_output_data;
    end
  end

  assign bus.mmu_if_read    = mmu_rd_q;
  assign bus.mmu_if_write   = mmu_wr_q;
  assign bus.mmu_addr       = mmu_addr_q;
  assign bus.mmu_input_data = mmu_wdata_q;
  assign bus.mmu_bytemode   = mmu_bm_q;
  assign bus.mem_ready      = mem_ready_q;
  assign bus.if_ready       = if_ready_q;
  assign bus.mem_rdata      = mem_rdata_q;
  assign bus.if_rdata       = if_rdata_q;
  assign bus.stall_req      = mem_eff | if_eff;

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-by-cycle vector bench for mem_arbiter, plus hand-written reset and
// back-to-back MEM/IF sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // MMU read model. It returns fixed data per address while the read strobe is up.
  function automatic logic [31:0] mmu_model(input logic [31:0] a);
    case (a)
      32'h80001004: return 32'hFFFFFF80;
      32'hBFD003FC: return 32'h00000003;
      32'h80000000: return 32'h11111111;
      32'h80000004: return 32'h22222222;
      32'h80000008: return 32'h33333333;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  assign bus.mmu_output_data = bus.mmu_if_read ? mmu_model(bus.mmu_addr) : 32'h0;

  typedef struct packed {
    logic        rst;
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [4:0]  mbm;
    logic        ireq;
    logic [31:0] iaddr;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  bm;
    logic        mrdy;
    logic        irdy;
    logic        stall;
    logic [31:0] mrdata;
    logic [31:0] irdata;
  } vec_t;

  vec_t vq[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   both_ready = 0;

  function automatic vec_t mk(
    input logic r, input logic mq, input logic mw, input logic [31:0] ma,
    input logic [31:0] md, input logic [4:0] mb, input logic iq, input logic [31:0] ia,
    input logic erd, input logic ewr, input logic [31:0] ea, input logic [31:0] ewd,
    input logic [4:0] ebm, input logic emr, input logic eir, input logic est,
    input logic [31:0] emd, input logic [31:0] eid);
    vec_t v;
    v.rst = r; v.mreq = mq; v.mwe = mw; v.maddr = ma; v.mwdata = md; v.mbm = mb;
    v.ireq = iq; v.iaddr = ia;
    v.rd = erd; v.wr = ewr; v.addr = ea; v.wdata = ewd; v.bm = ebm;
    v.mrdy = emr; v.irdy = eir; v.stall = est; v.mrdata = emd; v.irdata = eid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ready pulses must never overlap
  always @(negedge clk) if (bus.mem_ready && bus.if_ready) both_ready++;

  initial begin
    bus.if_req = 0; bus.if_addr = 0; bus.mem_req = 0; bus.mem_we = 0;
    bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_bytemode = 0;

    //            rst mq mw maddr         mwdata        mbm       iq ia            | rd wr addr          wdata         bm        mr ir st mrdata        irdata
    vq.push_back(mk(1, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 0, 32'h0,        32'h0));
    // single load
    vq.push_back(mk(0, 1, 0, 32'h80001004, 32'h0,        5'b00001, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 1, 32'h0,        32'h0));
    vq.push_back(mk(0, 1, 0, 32'h80001004, 32'h0,        5'b00001, 0, 32'h0,        1, 0, 32'h80001004, 32'h0,        5'b00001, 0, 0, 1, 32'h0,        32'h0));
    vq.push_back(mk(0, 1, 0, 32'h80001004, 32'h0,        5'b00001, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 1, 0, 0, 32'hFFFFFF80, 32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 0, 32'hFFFFFF80, 32'h0));
    // UART status load, bytemode passed through untouched
    vq.push_back(mk(0, 1, 0, 32'hBFD003FC, 32'h0,        5'b10001, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 1, 32'hFFFFFF80, 32'h0));
    vq.push_back(mk(0, 1, 0, 32'hBFD003FC, 32'h0,        5'b10001, 0, 32'h0,        1, 0, 32'hBFD003FC, 32'h0,        5'b10001, 0, 0, 1, 32'hFFFFFF80, 32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 1, 0, 0, 32'h00000003, 32'h0));
    // simultaneous store + fetch: MEM first, IF right behind
    vq.push_back(mk(0, 1, 1, 32'h80400000, 32'h12345678, 5'b01111, 1, 32'h80000000, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 1, 32'h00000003, 32'h0));
    vq.push_back(mk(0, 1, 1, 32'h80400000, 32'h12345678, 5'b01111, 1, 32'h80000000, 0, 1, 32'h80400000, 32'h12345678, 5'b01111, 0, 0, 1, 32'h00000003, 32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 1, 32'h80000000, 1, 0, 32'h80000000, 32'h0,        5'b01111, 1, 0, 1, 32'h00000003, 32'h0));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 0, 1, 0, 32'h00000003, 32'h11111111));
    // if_req held across two fetches: one issue every 3 cycles
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 1, 32'h80000000, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 1, 32'h00000003, 32'h11111111));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 1, 32'h80000000, 1, 0, 32'h80000000, 32'h0,        5'b01111, 0, 0, 1, 32'h00000003, 32'h11111111));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 1, 32'h80000004, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 1, 0, 32'h00000003, 32'h11111111));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 1, 32'h80000004, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 1, 32'h00000003, 32'h11111111));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 1, 32'h80000004, 1, 0, 32'h80000004, 32'h0,        5'b01111, 0, 0, 1, 32'h00000003, 32'h11111111));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 0, 1, 0, 32'h00000003, 32'h22222222));
    // MEM requesting continuously with IF pending
    vq.push_back(mk(0, 1, 0, 32'h80001004, 32'h0,        5'b00001, 1, 32'h80000008, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 1, 32'h00000003, 32'h22222222));
    vq.push_back(mk(0, 1, 0, 32'h80001004, 32'h0,        5'b00001, 1, 32'h80000008, 1, 0, 32'h80001004, 32'h0,        5'b00001, 0, 0, 1, 32'h00000003, 32'h22222222));
    vq.push_back(mk(0, 1, 0, 32'h80001008, 32'h0,        5'b00001, 1, 32'h80000008, 1, 0, 32'h80000008, 32'h0,        5'b01111, 1, 0, 1, 32'hFFFFFF80, 32'h22222222));
    vq.push_back(mk(0, 1, 0, 32'h80001008, 32'h0,        5'b00001, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 0, 1, 1, 32'hFFFFFF80, 32'h33333333));
    vq.push_back(mk(0, 1, 0, 32'h80001008, 32'h0,        5'b00001, 0, 32'h0,        1, 0, 32'h80001008, 32'h0,        5'b00001, 0, 0, 1, 32'hFFFFFF80, 32'h33333333));
    vq.push_back(mk(0, 0, 0, 32'h0,        32'h0,        5'b00000, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 1, 0, 0, 32'hDEADBEEF, 32'h33333333));
    // store that will be hit by reset during its issue cycle
    vq.push_back(mk(0, 1, 1, 32'h80400004, 32'hCAFEF00D, 5'b01111, 0, 32'h0,        0, 0, 32'h0,        32'h0,        5'b00000, 0, 0, 1, 32'hDEADBEEF, 32'h33333333));
    vq.push_back(mk(0, 1, 1, 32'h80400004, 32'hCAFEF00D, 5'b01111, 0, 32'h0,        0, 1, 32'h80400004, 32'hCAFEF00D, 5'b01111, 0, 0, 1, 32'hDEADBEEF, 32'h33333333));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst              = vq[i].rst;
      bus.mem_req      = vq[i].mreq;
      bus.mem_we       = vq[i].mwe;
      bus.mem_addr     = vq[i].maddr;
      bus.mem_wdata    = vq[i].mwdata;
      bus.mem_bytemode = vq[i].mbm;
      bus.if_req       = vq[i].ireq;
      bus.if_addr      = vq[i].iaddr;
      #1;
      chk($sformatf("row%0d.mmu_if_read", i),    {31'h0, bus.mmu_if_read},   {31'h0, vq[i].rd});
      chk($sformatf("row%0d.mmu_if_write", i),   {31'h0, bus.mmu_if_write},  {31'h0, vq[i].wr});
      chk($sformatf("row%0d.mmu_addr", i),       bus.mmu_addr,               vq[i].addr);
      chk($sformatf("row%0d.mmu_input_data", i), bus.mmu_input_data,         vq[i].wdata);
      chk($sformatf("row%0d.mmu_bytemode", i),   {27'h0, bus.mmu_bytemode},  {27'h0, vq[i].bm});
      chk($sformatf("row%0d.mem_ready", i),      {31'h0, bus.mem_ready},     {31'h0, vq[i].mrdy});
      chk($sformatf("row%0d.if_ready", i),       {31'h0, bus.if_ready},      {31'h0, vq[i].irdy});
      chk($sformatf("row%0d.stall_req", i),      {31'h0, bus.stall_req},     {31'h0, vq[i].stall});
      chk($sformatf("row%0d.mem_rdata", i),      bus.mem_rdata,              vq[i].mrdata);
      chk($sformatf("row%0d.if_rdata", i),       bus.if_rdata,               vq[i].irdata);
    end

    // Reset in the middle of the store's issue cycle: write strobe must drop at once
    #1;
    rst = 1'b1;
    bus.mem_req = 1'b0;
    #1;
    chk("rst.mmu_if_write", {31'h0, bus.mmu_if_write}, 32'h0);
    chk("rst.mmu_if_read",  {31'h0, bus.mmu_if_read},  32'h0);
    chk("rst.mmu_addr",     bus.mmu_addr,              32'h0);
    chk("rst.mmu_input",    bus.mmu_input_data,        32'h0);
    chk("rst.mmu_bytemode", {27'h0, bus.mmu_bytemode}, 32'h0);
    chk("rst.mem_rdata",    bus.mem_rdata,             32'h0);
    chk("rst.if_rdata",     bus.if_rdata,              32'h0);
    chk("rst.stall_req",    {31'h0, bus.stall_req},    32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.mem_ready0", {31'h0, bus.mem_ready}, 32'h0);
    @(negedge clk);
    #1;
    chk("post_rst.mem_ready1", {31'h0, bus.mem_ready},    32'h0);
    chk("post_rst.mmu_write",  {31'h0, bus.mmu_if_write}, 32'h0);

    // MEM and IF together with MEM held continuously: IF must finish within 4 cycles
    begin
      int waited = 0;
      int mem_seen_at = 0;
      logic got_if = 1'b0;
      @(negedge clk);
      bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h80001004; bus.mem_bytemode = 5'b00001;
      bus.if_req = 1;  bus.if_addr = 32'h80000008;
      while (!got_if && waited < 8) begin
        @(posedge clk);
        #1;
        waited++;
        if (bus.mem_ready && mem_seen_at == 0) mem_seen_at = waited;
        if (bus.if_ready) begin
          got_if = 1'b1;
          bus.if_req = 1'b0;
        end
      end
      chk("starve.if_ready_seen",   {31'h0, got_if}, 32'h1);
      chk("starve.if_cycles",       waited,          32'd3);
      chk("starve.mem_first_cycle", mem_seen_at,     32'd2);
      chk("starve.if_rdata",        bus.if_rdata,    32'h33333333);
      chk("starve.mem_rdata",       bus.mem_rdata,   32'hFFFFFF80);
      repeat (4) @(negedge clk);
      bus.mem_req = 1'b0;
      repeat (3) @(negedge clk);
    end

    chk("ready_overlap", both_ready, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
